puzzle_move_unit: RTL and testbench
===================================

# puzzle_move_unit

Applies one blank-tile move to an 8-puzzle board held in the 44-bit register file and writes the result back. It sits directly upstream of the register file: it drives the file's read address and consumes its read data, then drives its write port. It reports whether the move was legal and whether the new board equals the goal. It is a multi-cycle engine with a start/done handshake, serving the solver's search control.

## Interface

**Parameters**
- `WIDTH`, 44: register word width.
- `ADDR_W`, 5: register address width.

**Ports**
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `src_addr`, in, 5: register holding the source board.
- `dst_addr`, in, 5: register receiving the moved board.
- `dir`, in, 2: blank direction. 00 = up, 01 = down, 10 = left, 11 = right.
- `rf_src`, out, 5: register file read address.
- `rf_rdata`, in, 44: register file read data (combinational from `rf_src`).
- `rf_dst`, out, 5: register file write address.
- `rf_we`, out, 1: register file write enable.
- `rf_wdata`, out, 44: register file write data.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `illegal`, out, 1: move rejected.
- `is_goal`, out, 1: written board equals the goal.
- `blank_pos`, out, 4: cell index where the blank was found.

## Operation

**Board format**
- Cell p (0..8, row-major, top-left is 0) occupies nibble k = 8−p, i.e. bits [4k+3:4k].
- Value 0 is the blank.
- Bits [43:36] are the move-depth field.
- Goal is [35:0] = 36'h012345678.

**Latching**
- On an accepted `start`, latch `src_addr`, `dst_addr` and `dir`.
- Clear `illegal`, `is_goal` and `blank_pos`.

**States:** IDLE → LOAD → SCAN → SWAP → WRITE → IDLE, or → FAIL → IDLE.
- **LOAD:** `rf_src` = latched source address. Capture `rf_rdata` into the board register at the end of the cycle.
- **SCAN:** one cell per cycle, p = 0 upward. On the first cell with value 0, record `blank_pos` = p and go to SWAP. If cell 8 is nonzero, go to FAIL with `blank_pos` = 4'hF.
- **SWAP:** compute the target cell q. Let r = p/3 and c = p%3.
  - up: q = p−3, requires r > 0.
  - down: q = p+3, requires r < 2.
  - left: q = p−1, requires c > 0.
  - right: q = p+1, requires c < 2.
  - If the move is illegal, go to FAIL.
  - Otherwise: cell p ← old cell q, cell q ← 0, depth ← depth+1 mod 256 (0xFF wraps to 0x00).
  - Compute `is_goal` from the new [35:0].
- **WRITE:** `rf_we` = 1, `rf_dst` = latched destination, `rf_wdata` = new board, `done` = 1.
- **FAIL:** `done` = 1, `illegal` = 1, `rf_we` = 0, `is_goal` = 0.

**Result flags**
- `illegal`, `is_goal` and `blank_pos` hold their values until the next accepted `start`.

**Boundary cases**
- `start` while busy is ignored; no queuing.
- `src_addr` may equal `dst_addr`. The board is captured in LOAD, so overwrite is safe.
- Only the first zero nibble counts as the blank. Duplicate zeros are not checked.
- Nibble values 9..F are treated as ordinary tiles.
- `rst_n` low mid-operation: return to IDLE next edge. No write occurs, and any pending `done` is lost.

## Timing

- **Reset values:** state IDLE. `rf_src`, `rf_dst` = 0. `rf_wdata` = 0. `rf_we`, `busy`, `done`, `illegal`, `is_goal` = 0. `blank_pos` = 0.
- **Start:** accepted in cycle T; LOAD occupies T+1.
- **Scan:** covers T+2 .. T+2+p.
- **Legal move:** SWAP at T+3+p; WRITE (`rf_we` = `done` = 1) at T+4+p; IDLE at T+5+p.
- **Illegal move:** FAIL (`done`) at T+4+p.
- **No blank:** FAIL at T+12.
- **Back-to-back:** `start` is accepted in the IDLE cycle immediately after `done`.
- **Register file effect:** the write lands at the edge ending the WRITE cycle.
- **Outputs:** all outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Test plan

1. **Legal move up.**
   - Stimulus: reg0 = 44'h00142057368, start with src 0, dst 29, dir up at T.
   - Response: `blank_pos` = 3; at T+7 `rf_we`/`done` high, `rf_wdata` = 44'h01042157368, `illegal` = 0, `is_goal` = 0.
2. **Illegal edge move.**
   - Stimulus: same board, dir left.
   - Response: `done` and `illegal` high at T+7, `rf_we` never high, reg29 unchanged.
3. **Goal detection with in-place write.**
   - Stimulus: board 44'h00102345678 in reg 30, dir left, src = dst = 30.
   - Response: at T+5 `rf_wdata` = 44'h01012345678, `is_goal` = 1.
4. **No blank.**
   - Stimulus: board 44'h00123456789.
   - Response: `done` and `illegal` at T+12, `blank_pos` = 4'hF, no write.
5. **Depth wrap.**
   - Stimulus: board 44'hFF102345678, dir right.
   - Response: `rf_wdata` = 44'h00120345678.
6. **Busy and reset behaviour.**
   - Stimulus: pulse `start` during SCAN, then assert `rst_n` low at T+3.
   - Response: the second start is ignored; after reset `busy` = 0, `done` and `rf_we` never pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/puzzle_move_unit.sv
// Applies one blank-tile move to an 8-puzzle board read from the register file and
// writes the moved board back, reporting legality, goal match and the blank position.
module puzzle_move_unit #(
    parameter int unsigned WIDTH  = 44,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [1:0]        dir,
    output logic [ADDR_W-1:0] rf_src,
    input  logic [WIDTH-1:0]  rf_rdata,
    output logic [ADDR_W-1:0] rf_dst,
    output logic              rf_we,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              is_goal,
    output logic [3:0]        blank_pos
);

    localparam int unsigned CELLS     = 9;
    localparam int unsigned NIB       = 4;
    localparam int unsigned BOARD_W   = CELLS * NIB;
    localparam int unsigned DEPTH_W   = 8;
    localparam logic [BOARD_W-1:0] GOAL = 36'h012345678;
    localparam logic [3:0]   LAST_CELL = 4'd8;
    localparam logic [3:0]   NO_BLANK  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_SWAP, S_WRITE, S_FAIL
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    board_q, board_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          dir_q, dir_d;
    logic [ADDR_W-1:0]   rf_src_q, rf_src_d, rf_dst_q, rf_dst_d;
    logic [WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
    logic                rf_we_q, rf_we_d, busy_q, busy_d, done_q, done_d;
    logic                illegal_q, illegal_d, is_goal_q, is_goal_d;
    logic [3:0]          blank_pos_q, blank_pos_d;

    logic [3:0]          scan_cell_c, tgt_c, tgt_val_c;
    logic [1:0]          row_c, col_c;
    logic                move_ok_c;
    logic [WIDTH-1:0]    swapped_c;

    // Nibble under the scan pointer, plus row/column, target and legality of the blank
    always_comb begin
        scan_cell_c = 4'h0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (4'(k) == cnt_q) scan_cell_c = board_q[NIB*(CELLS-1-k) +: NIB];
        end
        row_c = (blank_pos_q < 4'd3) ? 2'd0 : (blank_pos_q < 4'd6) ? 2'd1 : 2'd2;
        col_c = 2'(blank_pos_q - 4'(row_c) * 4'd3);
        tgt_c     = blank_pos_q;
        move_ok_c = 1'b0;
        case (dir_q)
            2'd0: begin move_ok_c = (row_c != 2'd0); tgt_c = blank_pos_q - 4'd3; end
            2'd1: begin move_ok_c = (row_c != 2'd2); tgt_c = blank_pos_q + 4'd3; end
            2'd2: begin move_ok_c = (col_c != 2'd0); tgt_c = blank_pos_q - 4'd1; end
            default: begin move_ok_c = (col_c != 2'd2); tgt_c = blank_pos_q + 4'd1; end
        endcase
        if (blank_pos_q == NO_BLANK) move_ok_c = 1'b0;
    end

    // Board with blank and target swapped and depth bumped (wraps mod 256)
    always_comb begin
        tgt_val_c = 4'h0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (4'(k) == tgt_c) tgt_val_c = board_q[NIB*(CELLS-1-k) +: NIB];
        end
        swapped_c = board_q;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (4'(k) == blank_pos_q)  swapped_c[NIB*(CELLS-1-k) +: NIB] = tgt_val_c;
            else if (4'(k) == tgt_c)   swapped_c[NIB*(CELLS-1-k) +: NIB] = 4'h0;
        end
        swapped_c[BOARD_W +: DEPTH_W] = board_q[BOARD_W +: DEPTH_W] + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_SCAN;
            S_SCAN:  if (scan_cell_c == 4'h0 || cnt_q == LAST_CELL) state_d = S_SWAP;
            S_SWAP:  state_d = move_ok_c ? S_WRITE : S_FAIL;
            S_WRITE: state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        board_d     = board_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        rf_src_d    = rf_src_q;
        rf_dst_d    = rf_dst_q;
        rf_wdata_d  = rf_wdata_q;
        illegal_d   = illegal_q;
        is_goal_d   = is_goal_q;
        blank_pos_d = blank_pos_q;
        rf_we_d     = (state_d == S_WRITE);
        done_d      = (state_d == S_WRITE) || (state_d == S_FAIL);
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: if (start) begin
                rf_src_d    = src_addr;
                rf_dst_d    = dst_addr;
                dir_d       = dir;
                cnt_d       = 4'd0;
                illegal_d   = 1'b0;
                is_goal_d   = 1'b0;
                blank_pos_d = 4'd0;
            end
            S_LOAD: board_d = rf_rdata;
            S_SCAN: begin
                if (scan_cell_c == 4'h0)     blank_pos_d = cnt_q;
                else if (cnt_q == LAST_CELL) blank_pos_d = NO_BLANK;
                else                         cnt_d = cnt_q + 4'd1;
            end
            S_SWAP: begin
                if (move_ok_c) begin
                    rf_wdata_d = swapped_c;
                    is_goal_d  = (swapped_c[BOARD_W-1:0] == GOAL);
                end else begin
                    illegal_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            board_q     <= '0;
            cnt_q       <= '0;
            dir_q       <= '0;
            rf_src_q    <= '0;
            rf_dst_q    <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            is_goal_q   <= 1'b0;
            blank_pos_q <= '0;
        end else begin
            board_q     <= board_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            rf_src_q    <= rf_src_d;
            rf_dst_q    <= rf_dst_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            is_goal_q   <= is_goal_d;
            blank_pos_q <= blank_pos_d;
        end
    end

    assign rf_src    = rf_src_q;
    assign rf_dst    = rf_dst_q;
    assign rf_we     = rf_we_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign is_goal   = is_goal_q;
    assign blank_pos = blank_pos_q;

endmodule

// File: tb/tb_puzzle_move_unit.sv
// Bench for puzzle_move_unit: register-file model, directed plan cases and random
// moves checked against a cell-array reference of the move rules.
module tb_puzzle_move_unit;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [4:0]  src_addr, dst_addr, rf_src, rf_dst;
    logic [1:0]  dir;
    logic [43:0] rf_rdata, rf_wdata;
    logic        rf_we, busy, done, illegal, is_goal;
    logic [3:0]  blank_pos;

    logic [43:0] mem [32];
    logic        set_we = 1'b0;
    logic [4:0]  set_addr = '0;
    logic [43:0] set_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    puzzle_move_unit #(.WIDTH(44), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .dir(dir),
        .rf_src(rf_src), .rf_rdata(rf_rdata), .rf_dst(rf_dst),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .busy(busy), .done(done),
        .illegal(illegal), .is_goal(is_goal), .blank_pos(blank_pos)
    );

    assign rf_rdata = mem[rf_src];

    always @(posedge clk) begin
        if (rf_we)       mem[rf_dst]   <= rf_wdata;
        else if (set_we) mem[set_addr] <= set_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_mem(input logic [4:0] a, input logic [43:0] v);
        set_we = 1'b1; set_addr = a; set_data = v;
        @(negedge clk);
        set_we = 1'b0;
    endtask

    // Reference: unpack into cells, apply the move rules, repack
    function automatic void ref_move(input logic [43:0] b, input logic [1:0] dr,
                                     output bit legal, output logic [43:0] nb,
                                     output logic [3:0] bp, output bit goal, output int lat);
        int cells[9];
        int p = -1;
        int q = 0;
        legal = 0; nb = b; goal = 0;
        for (int i = 0; i < 9; i++) cells[i] = int'(b[4*(8-i) +: 4]);
        for (int i = 0; i < 9; i++) if (p < 0 && cells[i] == 0) p = i;
        if (p < 0) begin bp = 4'hF; lat = 12; return; end
        bp = 4'(p);
        lat = 4 + p;
        case (dr)
            2'd0: begin legal = (p / 3) > 0; q = p - 3; end
            2'd1: begin legal = (p / 3) < 2; q = p + 3; end
            2'd2: begin legal = (p % 3) > 0; q = p - 1; end
            default: begin legal = (p % 3) < 2; q = p + 1; end
        endcase
        if (!legal) return;
        cells[p] = cells[q];
        cells[q] = 0;
        nb[43:36] = b[43:36] + 8'd1;
        for (int i = 0; i < 9; i++) nb[4*(8-i) +: 4] = 4'(cells[i]);
        goal = 1;
        for (int i = 0; i < 9; i++) if (cells[i] != i) goal = 0;
    endfunction

    function automatic logic [43:0] rand_board();
        logic [43:0] b;
        int cells[9];
        int j, t;
        if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 9; i++) cells[i] = i;
            for (int i = 8; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = cells[i]; cells[i] = cells[j]; cells[j] = t;
            end
        end else begin
            for (int i = 0; i < 9; i++) cells[i] = int'($urandom_range(0, 15));
        end
        for (int i = 0; i < 9; i++) b[4*(8-i) +: 4] = 4'(cells[i]);
        b[43:36] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        return b;
    endfunction

    // One command; on entry and exit the bench sits at a negedge in an IDLE cycle
    task automatic do_op(input logic [4:0] s, input logic [4:0] d, input logic [1:0] dr,
                         input logic [43:0] board, input logic [43:0] dst_init,
                         input bit chain, input bit extra, output logic [43:0] exp_mem);
        bit legal, goal;
        logic [43:0] nb;
        logic [3:0] bp;
        int lat_exp, lat, nwe;
        ref_move(board, dr, legal, nb, bp, goal, lat_exp);
        if (!chain) begin
            if (s != d) write_mem(d, dst_init);
            write_mem(s, board);
        end
        exp_mem = legal ? nb : ((s == d) ? board : dst_init);
        src_addr = s; dst_addr = d; dir = dr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rf_src_load", 64'(rf_src), 64'(s));
        check("busy_load", 64'(busy), 64'd1);
        lat = 0; nwe = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge clk);
            start = (extra && k == 2);
            if (rf_we) nwe++;
            if (done) begin lat = k; break; end
        end
        check("latency", 64'(lat), 64'(lat_exp));
        check("we_at_done", 64'(rf_we), 64'(legal));
        check("illegal", 64'(illegal), 64'(!legal));
        check("blank_pos", 64'(blank_pos), 64'(bp));
        check("is_goal", 64'(is_goal), 64'(goal));
        if (legal) begin
            check("wdata", 64'(rf_wdata), 64'(nb));
            check("rf_dst", 64'(rf_dst), 64'(d));
        end
        @(negedge clk);
        check("busy_after", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd0);
        check("we_count", 64'(nwe), 64'(legal));
        check("mem_dst", 64'(mem[d]), 64'(exp_mem));
        check("illegal_hold", 64'(illegal), 64'(!legal));
        check("blank_hold", 64'(blank_pos), 64'(bp));
    endtask

    initial begin
        logic [43:0] em, prev_val;
        logic [4:0]  prev_d, s, d;
        int nd, nw;
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; dir = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_src", 64'(rf_src), 64'd0);
        check("rst_dst", 64'(rf_dst), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_flags", 64'({illegal, is_goal, blank_pos}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(5'd0, 5'd29, 2'd0, 44'h00142057368, 44'h0AAAAAAAAAA, 0, 0, em);
        check("plan1_wdata", 64'(em), 64'h01042157368);
        do_op(5'd0, 5'd29, 2'd2, 44'h00142057368, 44'h0BBBBBBBBBB, 0, 0, em);
        do_op(5'd30, 5'd30, 2'd2, 44'h00102345678, 44'h0, 0, 0, em);
        check("plan3_goal", 64'(is_goal), 64'd1);
        do_op(5'd4, 5'd5, 2'd1, 44'h00123456789, 44'h0CCCCCCCCCC, 0, 0, em);
        do_op(5'd6, 5'd6, 2'd3, 44'hFF102345678, 44'h0, 0, 0, em);
        check("plan5_wrap", 64'(em), 64'h00120345678);

        // Extra start during SCAN, then reset mid-operation
        write_mem(5'd7, 44'h0DDDDDDDDDD);
        write_mem(5'd3, 44'h00123405678);
        src_addr = 5'd3; dst_addr = 5'd7; dir = 2'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_src", 64'(rf_src), 64'd0);
        nd = 0; nw = 0;
        for (int k = 0; k < 14; k++) begin
            if (done) nd++;
            if (rf_we) nw++;
            @(negedge clk);
        end
        check("midrst_done", 64'(nd), 64'd0);
        check("midrst_we", 64'(nw), 64'd0);
        check("midrst_mem", 64'(mem[7]), 64'h0DDDDDDDDDD);
        do_op(5'd3, 5'd7, 2'd0, 44'h00123405678, 44'h0DDDDDDDDDD, 0, 0, em);

        prev_d = 5'd7; prev_val = em;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_op(prev_d, prev_d, 2'($urandom), prev_val, 44'h0, 1, 1'($urandom), em);
                d = prev_d;
            end else begin
                s = 5'($urandom);
                d = ($urandom_range(0, 4) == 0) ? s : 5'($urandom);
                do_op(s, d, 2'($urandom), rand_board(), {4'h0, 40'($urandom) ^ 40'h5A5A5A5A5A},
                      0, 1'($urandom), em);
            end
            prev_d = d; prev_val = em;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
